alu_cmd_sequencer: RTL and testbench

Multi-cycle command sequencer that drives the 16-bit combinational ALU as its initiator. It accepts register-to-register commands over a valid/ready handshake and reads operands from an internal 8x16 register file. It presents the operands and opcode to the ALU on registered outputs, samples the result and C/V/N/Z flags, writes back, and reports each completion on a one-cycle response strobe. The block sits between an instruction source or test host and the ALU; the ALU itself stays external.

---
 rtl/alu_cmd_sequencer.sv | 130 +++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// Three-phase command sequencer (IDLE/EXEC/WB) driving an external
// 16-bit ALU, with an 8x16 register file and registered status flags.
module alu_cmd_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [2:0]  cmd_rd,
  input  logic [2:0]  cmd_ra,
  input  logic [2:0]  cmd_rb,
  input  logic [15:0] cmd_imm,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [2:0]  alu_op,
  input  logic [15:0] alu_y,
  input  logic        alu_c,
  input  logic        alu_v,
  input  logic        alu_n,
  input  logic        alu_z,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        flag_c,
  output logic        flag_v,
  output logic        flag_n,
  output logic        flag_z,
  input  logic [2:0]  dbg_sel,
  output logic [15:0] dbg_data
);

  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_LDI = 3'b110;
  localparam logic [2:0] OP_CMP = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_e;

  state_e      state_q;
  logic [15:0] rf_q [8];
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic [2:0]  aop_q;
  logic [2:0]  op_q;
  logic [2:0]  rd_q;
  logic [15:0] imm_q;
  logic [15:0] res_q;
  logic [3:0]  cap_q;
  logic [3:0]  flg_q;
  logic        rsp_valid_q;
  logic [2:0]  aop_d;

  // CMP reuses the ALU subtractor; LDI bypasses the ALU entirely.
  always_comb begin
    aop_d = cmd_op;
    unique case (1'b1)
      cmd_op == OP_CMP: aop_d = OP_SUB;
      cmd_op == OP_LDI: aop_d = 3'b000;
      default:          aop_d = cmd_op;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      aop_q       <= '0;
      op_q        <= '0;
      rd_q        <= '0;
      imm_q       <= '0;
      res_q       <= '0;
      cap_q       <= '0;
      flg_q       <= '0;
      rsp_valid_q <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            a_q     <= rf_q[cmd_ra];
            b_q     <= rf_q[cmd_rb];
            aop_q   <= aop_d;
            op_q    <= cmd_op;
            rd_q    <= cmd_rd;
            imm_q   <= cmd_imm;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          res_q       <= (op_q == OP_LDI) ? imm_q : alu_y;
          cap_q       <= {alu_c, alu_v, alu_n, alu_z};
          rsp_valid_q <= 1'b1;
          state_q     <= WB;
        end
        WB: begin
          rsp_valid_q <= 1'b0;
          if (op_q != OP_CMP) begin
            rf_q[rd_q] <= res_q;
          end
          if (op_q != OP_LDI) begin
            flg_q <= cap_q;
          end
          state_q <= IDLE;
        end
        default: begin
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_op    = aop_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = res_q;
  assign flag_c    = flg_q[3];
  assign flag_v    = flg_q[2];
  assign flag_n    = flg_q[1];
  assign flag_z    = flg_q[0];
  assign dbg_data  = rf_q[dbg_sel];

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: external ALU model, command-level
// reference model, per-cycle compare and directed literal checks.
module tb_alu_cmd_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op, cmd_rd, cmd_ra, cmd_rb;
  logic [15:0] cmd_imm;
  logic [15:0] alu_a, alu_b, alu_y;
  logic [2:0]  alu_op;
  logic        alu_c, alu_v, alu_n, alu_z;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        flag_c, flag_v, flag_n, flag_z;
  logic [2:0]  dbg_sel;
  logic [15:0] dbg_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_cmd_sequencer dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd),
    .cmd_ra(cmd_ra), .cmd_rb(cmd_rb),
    .cmd_imm(cmd_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_y(alu_y), .alu_c(alu_c), .alu_v(alu_v),
    .alu_n(alu_n), .alu_z(alu_z),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .flag_c(flag_c), .flag_v(flag_v),
    .flag_n(flag_n), .flag_z(flag_z),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  // Reference ALU: {c,v,n,z,y}; logical ops force c/v/n to 0.
  function automatic logic [19:0] alu_f(
    input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    logic [15:0] y;
    logic c, v, n;
    c = 1'b0; v = 1'b0; n = 1'b0; y = '0;
    case (op)
      3'd0: begin
        s = {1'b0, a} + {1'b0, b};
        y = s[15:0]; c = s[16];
        v = (a[15] == b[15]) && (y[15] != a[15]);
        n = y[15];
      end
      3'd1, 3'd7: begin
        y = a - b; c = (a < b);
        v = (a[15] != b[15]) && (y[15] != a[15]);
        n = y[15];
      end
      3'd2: y = a & b;
      3'd3: y = a | b;
      3'd4: y = a ^ b;
      3'd5: y = ~a;
      default: y = '0;
    endcase
    return {c, v, n, (y == 16'h0), y};
  endfunction

  assign {alu_c, alu_v, alu_n, alu_z, alu_y} = alu_f(alu_op, alu_a, alu_b);

  function automatic logic [2:0] map_op(input logic [2:0] op);
    if (op == 3'd7) return 3'd1;
    if (op == 3'd6) return 3'd0;
    return op;
  endfunction

  function automatic logic [15:0] ref_res(input logic [2:0] op,
    input logic [15:0] a, input logic [15:0] b, input logic [15:0] imm);
    logic [19:0] r;
    r = alu_f(op, a, b);
    return (op == 3'd6) ? imm : r[15:0];
  endfunction

  function automatic logic [3:0] ref_flg(input logic [2:0] op,
    input logic [15:0] a, input logic [15:0] b);
    logic [19:0] r;
    r = alu_f(op, a, b);
    return r[19:16];
  endfunction

  // Command-level model: phase 0 idle, 1 exec, 2 writeback.
  int          m_ph;
  logic [15:0] m_rf [8];
  logic [15:0] m_a, m_b, m_res, m_rsp;
  logic [2:0]  m_aop, m_op, m_rd;
  logic [3:0]  m_fl, m_flags;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ph <= 0; m_a <= '0; m_b <= '0; m_aop <= '0;
      m_op <= '0; m_rd <= '0; m_res <= '0; m_rsp <= '0;
      m_fl <= '0; m_flags <= '0;
      for (int i = 0; i < 8; i++) m_rf[i] <= '0;
    end else if (m_ph == 0) begin
      if (cmd_valid) begin
        m_ph  <= 1;
        m_a   <= m_rf[cmd_ra];
        m_b   <= m_rf[cmd_rb];
        m_aop <= map_op(cmd_op);
        m_op  <= cmd_op;
        m_rd  <= cmd_rd;
        m_res <= ref_res(cmd_op, m_rf[cmd_ra], m_rf[cmd_rb], cmd_imm);
        m_fl  <= ref_flg(cmd_op, m_rf[cmd_ra], m_rf[cmd_rb]);
      end
    end else if (m_ph == 1) begin
      m_ph  <= 2;
      m_rsp <= m_res;
    end else begin
      m_ph <= 0;
      if (m_op != 3'd7) m_rf[m_rd] <= m_res;
      if (m_op != 3'd6) m_flags <= m_fl;
    end
  end

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("ready", {15'd0, cmd_ready}, {15'd0, m_ph == 0});
    chk("rsp_valid", {15'd0, rsp_valid}, {15'd0, m_ph == 2});
    chk("rsp_data", rsp_data, m_rsp);
    chk("alu_a", alu_a, m_a);
    chk("alu_b", alu_b, m_b);
    chk("alu_op", {13'd0, alu_op}, {13'd0, m_aop});
    chk("flags", {12'd0, flag_c, flag_v, flag_n, flag_z},
        {12'd0, m_flags});
    chk("dbg_data", dbg_data, m_rf[dbg_sel]);
  end

  task automatic issue(input logic [2:0] op, input logic [2:0] rd,
    input logic [2:0] ra, input logic [2:0] rb, input logic [15:0] imm,
    input logic lit, input logic [15:0] exp_rsp, input logic [2:0] exp_aop);
    int n;
    cmd_op = op; cmd_rd = rd; cmd_ra = ra; cmd_rb = rb;
    cmd_imm = imm; cmd_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (m_ph != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got busy expected idle");
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op = 3'($urandom); cmd_imm = 16'($urandom);
    cmd_rd = 3'($urandom); cmd_ra = 3'($urandom);
    @(negedge clk);
    if (lit) chk("lit_exec_aluop", {13'd0, alu_op}, {13'd0, exp_aop});
    @(negedge clk);
    if (lit) begin
      chk("lit_wb_valid", {15'd0, rsp_valid}, 16'd1);
      chk("lit_wb_data", rsp_data, exp_rsp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic post(input logic [3:0] fl, input logic [2:0] sel,
                      input logic [15:0] dv);
    dbg_sel = sel;
    @(negedge clk);
    chk("lit_flags", {12'd0, flag_c, flag_v, flag_n, flag_z}, {12'd0, fl});
    chk("lit_dbg", dbg_data, dv);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; dbg_sel = '0;
    cmd_op = '0; cmd_rd = '0; cmd_ra = '0; cmd_rb = '0; cmd_imm = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {15'd0, cmd_ready}, 16'd1);
    chk("rst_rsp_valid", {15'd0, rsp_valid}, 16'd0);
    chk("rst_rsp_data", rsp_data, 16'd0);
    chk("rst_alu_a", alu_a, 16'd0);
    chk("rst_alu_op", {13'd0, alu_op}, 16'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    post(4'b0000, 3'd0, 16'h0000);

    issue(3'd6, 3'd1, 3'd0, 3'd0, 16'h7FFF, 1'b1, 16'h7FFF, 3'd0);
    post(4'b0000, 3'd1, 16'h7FFF);
    issue(3'd6, 3'd2, 3'd5, 3'd6, 16'h0001, 1'b1, 16'h0001, 3'd0);
    post(4'b0000, 3'd2, 16'h0001);
    issue(3'd0, 3'd3, 3'd1, 3'd2, 16'hDEAD, 1'b1, 16'h8000, 3'd0);
    post(4'b0110, 3'd3, 16'h8000);
    issue(3'd6, 3'd4, 3'd0, 3'd0, 16'h1234, 1'b1, 16'h1234, 3'd0);
    post(4'b0110, 3'd4, 16'h1234);
    issue(3'd7, 3'd4, 3'd4, 3'd4, 16'h5555, 1'b1, 16'h0000, 3'd1);
    post(4'b0001, 3'd4, 16'h1234);

    issue(3'd6, 3'd1, 3'd0, 3'd0, 16'hF0F0, 1'b1, 16'hF0F0, 3'd0);
    issue(3'd6, 3'd2, 3'd0, 3'd0, 16'hFF00, 1'b1, 16'hFF00, 3'd0);
    post(4'b0001, 3'd2, 16'hFF00);
    issue(3'd2, 3'd5, 3'd1, 3'd2, 16'h0, 1'b1, 16'hF000, 3'd2);
    post(4'b0000, 3'd5, 16'hF000);
    issue(3'd3, 3'd6, 3'd1, 3'd2, 16'h0, 1'b1, 16'hFFF0, 3'd3);
    post(4'b0000, 3'd6, 16'hFFF0);
    issue(3'd4, 3'd7, 3'd1, 3'd2, 16'h0, 1'b1, 16'h0FF0, 3'd4);
    post(4'b0000, 3'd7, 16'h0FF0);
    issue(3'd5, 3'd0, 3'd1, 3'd7, 16'h0, 1'b1, 16'h0F0F, 3'd5);
    post(4'b0000, 3'd0, 16'h0F0F);

    cmd_op = 3'd6; cmd_rd = 3'd1; cmd_imm = 16'h0003;
    cmd_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk("b2b_ready", {15'd0, cmd_ready}, {15'd0, (i % 3) == 0});
      chk("b2b_rsp", {15'd0, rsp_valid}, {15'd0, (i % 3) == 2});
      if ((i % 3) == 2) chk("b2b_data", rsp_data, 16'h0003);
      @(posedge clk);
      #1;
      if (i == 6) cmd_valid = 1'b0;
    end
    @(posedge clk);
    #1;

    cmd_op = 3'd0; cmd_rd = 3'd5; cmd_ra = 3'd1; cmd_rb = 3'd2;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    #2;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_rsp", {15'd0, rsp_valid}, 16'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    dbg_sel = 3'd5;
    @(negedge clk);
    chk("rst_mid_ready", {15'd0, cmd_ready}, 16'd1);
    chk("rst_mid_rsp2", {15'd0, rsp_valid}, 16'd0);
    chk("rst_mid_r5", dbg_data, 16'd0);
    chk("rst_mid_flags", {12'd0, flag_c, flag_v, flag_n, flag_z}, 16'd0);
    @(posedge clk);
    #1;

    issue(3'd6, 3'd1, 3'd0, 3'd0, 16'h0003, 1'b1, 16'h0003, 3'd0);
    issue(3'd0, 3'd1, 3'd1, 3'd1, 16'h0, 1'b1, 16'h0006, 3'd0);
    post(4'b0000, 3'd1, 16'h0006);
    issue(3'd1, 3'd2, 3'd1, 3'd1, 16'h0, 1'b1, 16'h0000, 3'd1);
    post(4'b0001, 3'd2, 16'h0000);

    for (int k = 0; k < 300; k++) begin
      dbg_sel = 3'($urandom);
      issue(3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
            16'($urandom), 1'b0, 16'h0, 3'd0);
      repeat ($urandom_range(0, 2)) begin
        dbg_sel = 3'($urandom);
        @(posedge clk);
        #1;
      end
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
